// File: rtl/fifo_shadow_checker_pkg.sv
// Shared definitions for the FIFO shadow checker.
// - chk_bit_e   : bit positions inside mismatch_vec / first_err_vec
// - NUM_CHK     : number of compared FIFO outputs
// - exp_flags_t : predicted FIFO flag outputs produced by the shadow model
package pkg_fifo_chk;

  localparam int NUM_CHK = 8;

  typedef enum logic [2:0] {
    DATA        = 3'd0,
    WR_ACK      = 3'd1,
    OVERFLOW    = 3'd2,
    UNDERFLOW   = 3'd3,
    FULL        = 3'd4,
    EMPTY       = 3'd5,
    ALMOSTFULL  = 3'd6,
    ALMOSTEMPTY = 3'd7
  } chk_bit_e;

  typedef struct packed {
    logic wr_ack;
    logic overflow;
    logic underflow;
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } exp_flags_t;

endpackage

// File: rtl/fifo_shadow_checker_model.sv
// Shadow model of a synchronous FIFO. Tracks contents, pointers and
// occupancy from the observed requests and predicts every DUT output.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, rd_en      observed requests
//   data_in           observed write data
//   exp_data          predicted registered data_out
//   exp_flags         predicted registered (wr_ack/overflow/underflow) and
//                     combinational (full/empty/almostfull/almostempty) flags
module fifo_shadow_model
  import pkg_fifo_chk::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] exp_data,
  output exp_flags_t            exp_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_M1 = (PTR_W+1)'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0] ONE_C    = (PTR_W+1)'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_wr;
  logic                  do_rd;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;

  // Acceptance depends only on the pre-edge count, so a simultaneous
  // request on an empty FIFO is write-only and on a full FIFO read-only.
  assign do_wr = wr_en && (count != DEPTH_C);
  assign do_rd = rd_en && (count != '0);

  // Storage carries no reset: stale words are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      exp_data    <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr   <= rd_ptr + 1'b1;
        exp_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wr_ack_q    <= do_wr;
      overflow_q  <= wr_en && (count == DEPTH_C);
      underflow_q <= rd_en && (count == '0);
    end
  end

  always_comb begin
    exp_flags             = '0;
    exp_flags.wr_ack      = wr_ack_q;
    exp_flags.overflow    = overflow_q;
    exp_flags.underflow   = underflow_q;
    exp_flags.full        = (count == DEPTH_C);
    exp_flags.empty       = (count == '0);
    exp_flags.almostfull  = (count == DEPTH_M1);
    exp_flags.almostempty = (count == ONE_C);
  end

endmodule

// File: rtl/fifo_shadow_checker.sv
// Synthesizable checker sitting beside a synchronous FIFO. Compares every
// observed FIFO output against the shadow model each clock, reports the
// per-signal result one cycle later and keeps saturating statistics.
// Ports:
//   clk, rst_n                 shared FIFO clock / async active-low reset
//   chk_en                     1 = compare and count, 0 = model only
//   data_in, wr_en, rd_en      observed FIFO inputs
//   data_out, wr_ack, overflow, underflow,
//   full, empty, almostfull, almostempty   observed FIFO outputs
//   chk_valid                  a comparison was made at the last edge
//   mismatch, mismatch_vec     result of that comparison (bit order: chk_bit_e)
//   correct_count, error_count saturating pass/fail counters
//   first_err_vec, first_err_cycle, err_seen  first-failure capture
module fifo_shadow_checker
  import pkg_fifo_chk::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chk_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  output logic                  chk_valid,
  output logic                  mismatch,
  output logic [NUM_CHK-1:0]    mismatch_vec,
  output logic [CNT_W-1:0]      correct_count,
  output logic [CNT_W-1:0]      error_count,
  output logic [NUM_CHK-1:0]    first_err_vec,
  output logic [CNT_W-1:0]      first_err_cycle,
  output logic                  err_seen
);

  logic [FIFO_WIDTH-1:0] exp_data;
  exp_flags_t            exp_flags;
  logic [NUM_CHK-1:0]    diff_p0;
  logic [CNT_W-1:0]      cycle_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fifo_shadow_model #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_model (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .exp_data (exp_data),
    .exp_flags(exp_flags)
  );

  // Stage p0: pre-edge DUT outputs against pre-edge predictions.
  always_comb begin
    diff_p0              = '0;
    diff_p0[DATA]        = (data_out    != exp_data);
    diff_p0[WR_ACK]      = (wr_ack      != exp_flags.wr_ack);
    diff_p0[OVERFLOW]    = (overflow    != exp_flags.overflow);
    diff_p0[UNDERFLOW]   = (underflow   != exp_flags.underflow);
    diff_p0[FULL]        = (full        != exp_flags.full);
    diff_p0[EMPTY]       = (empty       != exp_flags.empty);
    diff_p0[ALMOSTFULL]  = (almostfull  != exp_flags.almostfull);
    diff_p0[ALMOSTEMPTY] = (almostempty != exp_flags.almostempty);
  end

  // Stage p1: registered result, counters and first-error capture.
  // cycle_cnt holds the index of the edge being evaluated (0 = first edge
  // after reset release).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt       <= '0;
      chk_valid       <= 1'b0;
      mismatch        <= 1'b0;
      mismatch_vec    <= '0;
      correct_count   <= '0;
      error_count     <= '0;
      first_err_vec   <= '0;
      first_err_cycle <= '0;
      err_seen        <= 1'b0;
    end else begin
      cycle_cnt <= sat_inc(cycle_cnt);
      chk_valid <= chk_en;
      if (chk_en) begin
        mismatch     <= |diff_p0;
        mismatch_vec <= diff_p0;
        if (|diff_p0) begin
          error_count <= sat_inc(error_count);
          if (!err_seen) begin
            err_seen        <= 1'b1;
            first_err_vec   <= diff_p0;
            first_err_cycle <= cycle_cnt;
          end
        end else begin
          correct_count <= sat_inc(correct_count);
        end
      end else begin
        mismatch     <= 1'b0;
        mismatch_vec <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_shadow_checker.sv
module tb_fifo_shadow_checker;

  localparam int W = 16;
  localparam int D = 8;
  localparam int CW = 16;
  localparam int CMAX = 65535;

  logic          clk;
  logic          rst_n;
  logic          chk_en;
  logic [W-1:0]  data_in;
  logic          wr_en;
  logic          rd_en;
  logic [W-1:0]  data_out;
  logic          wr_ack;
  logic          overflow;
  logic          underflow;
  logic          full;
  logic          empty;
  logic          almostfull;
  logic          almostempty;
  logic          chk_valid;
  logic          mismatch;
  logic [7:0]    mismatch_vec;
  logic [CW-1:0] correct_count;
  logic [CW-1:0] error_count;
  logic [7:0]    first_err_vec;
  logic [CW-1:0] first_err_cycle;
  logic          err_seen;

  fifo_shadow_checker #(
    .FIFO_WIDTH(W),
    .FIFO_DEPTH(D),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .chk_en         (chk_en),
    .data_in        (data_in),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .data_out       (data_out),
    .wr_ack         (wr_ack),
    .overflow       (overflow),
    .underflow      (underflow),
    .full           (full),
    .empty          (empty),
    .almostfull     (almostfull),
    .almostempty    (almostempty),
    .chk_valid      (chk_valid),
    .mismatch       (mismatch),
    .mismatch_vec   (mismatch_vec),
    .correct_count  (correct_count),
    .error_count    (error_count),
    .first_err_vec  (first_err_vec),
    .first_err_cycle(first_err_cycle),
    .err_seen       (err_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed FIFO emulation (queue based) that drives the checker inputs.
  logic [W-1:0] q[$];
  logic [W-1:0] e_dout;
  bit           e_ack, e_ov, e_un;

  // Bench-side expectations of the checker statistics.
  int           n_checks, n_err;
  int           exp_cor, exp_errc, ncyc;
  bit           exp_seen;
  logic [7:0]   exp_fvec;
  int           exp_fcyc;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [W-1:0] din;
    bit         ce;
    logic [7:0] cor;      // which presented DUT outputs are corrupted
    logic [7:0] exp_vec;  // required mismatch_vec after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit wr, input bit rd, input logic [W-1:0] din,
                              input bit ce, input logic [7:0] cor, input logic [7:0] ev);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.ce = ce; v.cor = cor; v.exp_vec = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    e_dout = '0; e_ack = 0; e_ov = 0; e_un = 0;
    exp_cor = 0; exp_errc = 0; ncyc = 0;
    exp_seen = 0; exp_fvec = '0; exp_fcyc = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, " chk_valid"}, chk_valid, 0);
    check({tag, " mismatch"}, mismatch, 0);
    check({tag, " vec"}, mismatch_vec, 0);
    check({tag, " correct"}, correct_count, 0);
    check({tag, " errors"}, error_count, 0);
    check({tag, " first_vec"}, first_err_vec, 0);
    check({tag, " first_cyc"}, first_err_cycle, 0);
    check({tag, " err_seen"}, err_seen, 0);
    clear_model();
    wr_en = 0; rd_en = 0; data_in = '0; chk_en = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: present inputs and (possibly corrupted) DUT outputs, take the
  // edge, advance the emulated FIFO, then check the registered verdict.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d, input bit ce,
                      input logic [7:0] cor, input logic [7:0] ev, input string tag);
    int sz;
    int cyc_at;
    sz = q.size();
    wr_en = w; rd_en = r; data_in = d; chk_en = ce;
    data_out    = e_dout ^ (cor[0] ? 16'h0010 : 16'h0000);
    wr_ack      = e_ack ^ cor[1];
    overflow    = e_ov ^ cor[2];
    underflow   = e_un ^ cor[3];
    full        = (sz == D)     ^ cor[4];
    empty       = (sz == 0)     ^ cor[5];
    almostfull  = (sz == D - 1) ^ cor[6];
    almostempty = (sz == 1)     ^ cor[7];
    @(posedge clk);
    cyc_at = (ncyc > CMAX) ? CMAX : ncyc;
    ncyc++;
    e_ov  = w && (sz == D);
    e_un  = r && (sz == 0);
    e_ack = w && (sz < D);
    if (r && sz > 0) e_dout = q.pop_front();
    if (e_ack) q.push_back(d);
    if (ce) begin
      if (ev != 8'h00) begin
        exp_errc++;
        if (!exp_seen) begin
          exp_seen = 1; exp_fvec = ev; exp_fcyc = cyc_at;
        end
      end else if (exp_cor < CMAX) begin
        exp_cor++;
      end
    end
    #1;
    check({tag, " chk_valid"}, chk_valid, ce);
    check({tag, " vec"}, mismatch_vec, ev);
    check({tag, " mismatch"}, mismatch, (ev != 8'h00));
    check({tag, " correct"}, correct_count, exp_cor);
    check({tag, " errors"}, error_count, exp_errc);
    check({tag, " err_seen"}, err_seen, exp_seen);
    check({tag, " first_vec"}, first_err_vec, exp_fvec);
    check({tag, " first_cyc"}, first_err_cycle, exp_fcyc);
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst_n = 1'b1; chk_en = 1'b1; wr_en = 0; rd_en = 0; data_in = '0;
    data_out = '0; wr_ack = 0; overflow = 0; underflow = 0;
    full = 0; empty = 1; almostfull = 0; almostempty = 0;

    // Idle, fill 0x0001..0x0008 plus one overflowing write, drain with the
    // word read out by the 3rd read (0x0003) corrupted to 0x0013, then the
    // simultaneous read/write corners on empty and on full.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 8'h00));
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(1, 0, 16'(i), 1, 8'h00, 8'h00));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 1, 16'h0000, 1, (i == 4) ? 8'h01 : 8'h00, (i == 4) ? 8'h01 : 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 16'h00A1, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 8'h00));
    for (int i = 2; i <= 8; i++) tbl.push_back(mk(1, 0, 16'h00A0 + 16'(i), 1, 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 16'h00A9, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 8'h00));

    #2;
    do_reset("reset");

    for (int i = 0; i < 4; i++)
      step(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].ce, tbl[i].cor, tbl[i].exp_vec,
           $sformatf("v%0d", i));
    check("idle correct", correct_count, 4);
    check("idle errors", error_count, 0);
    check("idle err_seen", err_seen, 0);

    for (int i = 4; i < tbl.size(); i++)
      step(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].ce, tbl[i].cor, tbl[i].exp_vec,
           $sformatf("v%0d", i));
    check("table correct", correct_count, 32);
    check("table errors", error_count, 1);
    check("table first_vec", first_err_vec, 8'h01);
    check("table first_cyc", first_err_cycle, 16);

    // chk_en low with a corrupted full flag: nothing counted.
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0000, 0, 8'h10, 8'h00, $sformatf("off%0d", i));
    check("off correct", correct_count, 32);
    check("off errors", error_count, 1);
    step(0, 0, 16'h0000, 1, 8'h10, 8'h10, "on");
    check("on errors", error_count, 2);
    check("on first_vec", first_err_vec, 8'h01);

    // Reset in the middle of traffic, then new data must come back.
    step(1, 0, 16'hB001, 1, 8'h00, 8'h00, "pre_w1");
    step(1, 0, 16'hB002, 1, 8'h00, 8'h00, "pre_w2");
    step(1, 0, 16'hB003, 1, 8'h00, 8'h00, "pre_w3");
    do_reset("midreset");
    step(1, 0, 16'hC001, 1, 8'h00, 8'h00, "post_w");
    step(0, 1, 16'h0000, 1, 8'h00, 8'h00, "post_r");
    step(0, 0, 16'h0000, 1, 8'h00, 8'h00, "post_i1");
    step(0, 0, 16'h0000, 1, 8'h00, 8'h00, "post_i2");
    check("post correct", correct_count, 4);
    check("post errors", error_count, 0);

    // Long conforming idle run to drive the counters into saturation.
    repeat (65540) @(posedge clk);
    #1;
    ncyc += 65540;
    exp_cor = CMAX;
    check("sat correct", correct_count, CMAX);
    check("sat errors", error_count, 0);
    step(0, 0, 16'h0000, 1, 8'h20, 8'h20, "sat_err");
    check("sat first_cyc", first_err_cycle, CMAX);
    check("sat correct hold", correct_count, CMAX);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_shadow_checker.md
# fifo_shadow_checker

Synthesizable, parametrised checker that observes one synchronous FIFO instance and predicts its behaviour cycle by cycle. It replaces bench-side golden-model checking, so the same checker runs in simulation, emulation and FPGA prototypes. It keeps a shadow copy of the FIFO contents and occupancy, compares every observed DUT output against its prediction, and reports per-signal mismatches with pass/fail counters and first-error capture. It sits beside the FIFO and connects to the same signals the FIFO interface exposes.

## Interface
- FIFO_WIDTH, 16, data width of observed FIFO
- FIFO_DEPTH, 8, FIFO depth; power of two, ≥ 4
- CNT_W, 16, width of correct/error/cycle counters
- clk  in  1  shared FIFO clock
- rst_n  in  1  asynchronous, active-low reset; shared with the DUT; clears everything
- chk_en  in  1  1 = compare and count; 0 = model tracks, nothing counted
- data_in  in  FIFO_WIDTH  observed write data
- wr_en, rd_en  in  1 each  observed requests
- data_out  in  FIFO_WIDTH  observed DUT read data
- wr_ack, overflow, underflow  in  1 each  observed registered DUT flags
- full, empty, almostfull, almostempty  in  1 each  observed DUT status
- chk_valid  out  1  a comparison was evaluated this cycle (registered)
- mismatch  out  1  one-cycle pulse: at least one signal differed
- mismatch_vec  out  8  per-signal mismatch, bit order from package
- correct_count, error_count  out  CNT_W each  saturating counters
- first_err_vec  out  8  sticky mismatch_vec of first failing cycle
- first_err_cycle  out  CNT_W  cycle index of first failure
- err_seen  out  1  sticky; set with first mismatch

## Operation
- DUT contract being checked, evaluated at each posedge from sampled wr_en/rd_en and model count C:
  - write accepted iff wr_en && C < DEPTH
  - read accepted iff rd_en && C > 0
  - both requested, C == 0: write only; C == DEPTH: read only; otherwise both, C unchanged
  - next data_out = head word on accepted read, else hold
  - wr_ack = accepted write; overflow = wr_en && C == DEPTH; underflow = rd_en && C == 0 (all registered)
  - full = (C == DEPTH), empty = (C == 0), almostfull = (C == DEPTH-1), almostempty = (C == 1); combinational from current C
- Model: DEPTH×WIDTH shadow RAM, wrap-around wr/rd pointers of log2(DEPTH) bits, C of log2(DEPTH)+1 bits.
- Compare at every posedge with chk_en=1: pre-edge DUT outputs vs pre-edge expected registers and flags. All 8 bits equal → correct_count++; otherwise error_count++, mismatch pulse.
- The first mismatch loads first_err_vec and first_err_cycle and sets err_seen; later errors do not overwrite. The cycle counter counts posedges since reset.
- Counters saturate at 2^CNT_W−1 and do not wrap.

## Timing
- Reset (async assert): model empty, expected data_out=0, expected flags 0, counters 0, all outputs 0 except that the expected empty flag is 1.
- First compare at the first posedge after rst_n deassert. The result appears on chk_valid/mismatch/mismatch_vec one cycle later (registered). Counters update on the same edge as the result.
- Write-to-read-visibility: a word written at edge k is readable at edge k+1. The readout appears on data_out after that edge.
- Reset mid-operation: immediate clear of model and counters. No compare in the cycle that rst_n is low.
- chk_en toggling: takes effect at the next posedge. The model always advances.

## Structure
- Package pkg_fifo_chk holds:
  - mismatch bit indices as an enum: DATA=0, WR_ACK, OVERFLOW, UNDERFLOW, FULL, EMPTY, ALMOSTFULL, ALMOSTEMPTY=7
  - the NUM_CHK=8 constant
  - the expected-output struct typedef
- Sub-module fifo_shadow_model contains the RAM, pointers, count and expected outputs. The top holds compare, counters and capture.

## Test plan
- Reset, idle 4 cycles, conforming DUT → correct_count=4, error_count=0, err_seen=0.
- Write 0x0001..0x0008 (DEPTH=8), one extra write, then 8 reads → expected overflow=1 on the 9th write; reads return 0x0001..0x0008; error_count=0.
- Corrupt DUT data_out on 3rd read (0x0003→0x0013) → mismatch=1 with mismatch_vec=0x01, error_count=1, first_err_vec=0x01, first_err_cycle = that cycle index.
- wr_en=rd_en=1 while empty, then while full → empty: wr_ack=1, underflow=1, C=1; full: read only, overflow=1, C=7.
- chk_en=0 for 5 cycles with a corrupted full flag → counters unchanged; chk_en=1 → error_count increments with mismatch_vec=0x10.
- rst_n pulsed low after 3 writes → all outputs 0 immediately; the next write/read returns the new data, not stale data.
